// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants, FSM encoding and small helpers for the two-port AXI read arbiter.
package axi_rd_arbiter_pkg;

    localparam int unsigned REQ_INST = 0;
    localparam int unsigned REQ_DATA = 1;
    localparam int unsigned NUM_REQ  = 2;

    localparam int unsigned LEN_W    = 4;
    localparam int unsigned SIZE_W   = 3;
    localparam int unsigned BURST_W  = 2;
    localparam int unsigned RESP_W   = 2;

    localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // One-hot requester vector for a requester index.
    function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AR/R bundle for the read arbiter: packed two-requester upstream side plus the single downstream port.
interface axi_rd_arbiter_if #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    import axi_rd_arbiter_pkg::*;

    logic [NUM_REQ*ID_W-1:0]    s_arid;
    logic [NUM_REQ*ADDR_W-1:0]  s_araddr;
    logic [NUM_REQ*LEN_W-1:0]   s_arlen;
    logic [NUM_REQ*SIZE_W-1:0]  s_arsize;
    logic [NUM_REQ*BURST_W-1:0] s_arburst;
    logic [NUM_REQ-1:0]         s_arvalid;
    logic [NUM_REQ-1:0]         s_arready;
    logic [ID_W-1:0]            s_rid;
    logic [DATA_W-1:0]          s_rdata;
    logic [RESP_W-1:0]          s_rresp;
    logic                       s_rlast;
    logic [NUM_REQ-1:0]         s_rvalid;
    logic [NUM_REQ-1:0]         s_rready;

    logic [ID_W-1:0]            m_arid;
    logic [ADDR_W-1:0]          m_araddr;
    logic [LEN_W-1:0]           m_arlen;
    logic [SIZE_W-1:0]          m_arsize;
    logic [BURST_W-1:0]         m_arburst;
    logic                       m_arvalid;
    logic                       m_arready;
    logic [ID_W-1:0]            m_rid;
    logic [DATA_W-1:0]          m_rdata;
    logic [RESP_W-1:0]          m_rresp;
    logic                       m_rlast;
    logic                       m_rvalid;
    logic                       m_rready;

    // Arbiter view
    modport slave (
        input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
        output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
        input  m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid
    );

    // Environment view: requesters plus downstream memory
    modport master (
        output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
        input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
        output m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid
    );

endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to whoever was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI3 read port between the instruction-fetch (0) and data (1) requesters,
// one outstanding burst at a time, with R beats routed back to the granted requester.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned ID_W       = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter logic        FIRST_PRIO = 1'b1
) (
    input  logic            aclk,
    input  logic            aresetn,
    axi_rd_arbiter_if.slave bus
);

    state_t               state;
    logic                 grant;
    logic                 last_grant;
    logic [ID_W-1:0]      ar_id;
    logic [ADDR_W-1:0]    ar_addr;
    logic [LEN_W-1:0]     ar_len;
    logic [SIZE_W-1:0]    ar_size;
    logic [BURST_W-1:0]   ar_burst;

    logic [NUM_REQ-1:0]   win_gnt;
    logic                 win_idx;
    logic                 in_idle;
    logic                 in_data;
    logic                 r_done;

    logic [ID_W-1:0]      sel_id;
    logic [ADDR_W-1:0]    sel_addr;
    logic [LEN_W-1:0]     sel_len;
    logic [SIZE_W-1:0]    sel_size;
    logic [BURST_W-1:0]   sel_burst;

    rr_arb2 u_rr_arb2 (
        .req  (bus.s_arvalid),
        .last (last_grant),
        .gnt  (win_gnt)
    );

    assign win_idx = win_gnt[REQ_DATA];
    assign in_idle = (state == ST_IDLE);
    assign in_data = (state == ST_DATA);
    assign r_done  = bus.m_rvalid && bus.m_rready && bus.m_rlast;

    // Winner's AR fields out of the packed request vectors
    assign sel_id    = win_idx ? bus.s_arid[REQ_DATA*ID_W +: ID_W]
                               : bus.s_arid[REQ_INST*ID_W +: ID_W];
    assign sel_addr  = win_idx ? bus.s_araddr[REQ_DATA*ADDR_W +: ADDR_W]
                               : bus.s_araddr[REQ_INST*ADDR_W +: ADDR_W];
    assign sel_len   = win_idx ? bus.s_arlen[REQ_DATA*LEN_W +: LEN_W]
                               : bus.s_arlen[REQ_INST*LEN_W +: LEN_W];
    assign sel_size  = win_idx ? bus.s_arsize[REQ_DATA*SIZE_W +: SIZE_W]
                               : bus.s_arsize[REQ_INST*SIZE_W +: SIZE_W];
    assign sel_burst = win_idx ? bus.s_arburst[REQ_DATA*BURST_W +: BURST_W]
                               : bus.s_arburst[REQ_INST*BURST_W +: BURST_W];

    // State, grant and latched AR request
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= ~FIRST_PRIO;
            ar_id      <= '0;
            ar_addr    <= '0;
            ar_len     <= '0;
            ar_size    <= '0;
            ar_burst   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|bus.s_arvalid) begin
                        grant      <= win_idx;
                        last_grant <= win_idx;
                        ar_id      <= sel_id;
                        ar_addr    <= sel_addr;
                        ar_len     <= sel_len;
                        ar_size    <= sel_size;
                        ar_burst   <= sel_burst;
                        state      <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus.m_arready) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Gated on aresetn so a held request cannot see a ready while in reset
    assign bus.s_arready = (in_idle && aresetn) ? win_gnt : NUM_REQ'(0);

    assign bus.m_arvalid = (state == ST_ADDR);
    assign bus.m_arid    = ar_id;
    assign bus.m_araddr  = ar_addr;
    assign bus.m_arlen   = ar_len;
    assign bus.m_arsize  = ar_size;
    assign bus.m_arburst = ar_burst;

    // R path follows the grant register only; m_rid is passed through unchecked
    assign bus.m_rready  = in_data && bus.s_rready[grant];
    assign bus.s_rvalid  = (in_data && bus.m_rvalid) ? req_onehot(grant) : NUM_REQ'(0);
    assign bus.s_rid     = in_data ? bus.m_rid   : ID_W'(0);
    assign bus.s_rdata   = in_data ? bus.m_rdata : DATA_W'(0);
    assign bus.s_rresp   = in_data ? bus.m_rresp : RESP_W'(0);
    assign bus.s_rlast   = in_data && bus.m_rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus randomized traffic against a grant-order model.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam logic FIRST_PRIO    = 1'b1;

    logic aclk = 1'b0;
    logic aresetn;
    int   errors;
    int   checks;
    logic model_last;

    logic [ID_W-1:0]    f_id    [2];
    logic [ADDR_W-1:0]  f_addr  [2];
    logic [LEN_W-1:0]   f_len   [2];
    logic [SIZE_W-1:0]  f_size  [2];
    logic [BURST_W-1:0] f_burst [2];

    axi_rd_arbiter_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi_rd_arbiter #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIRST_PRIO(FIRST_PRIO)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    // Arbitration rule: lone requester wins; on a tie, the one not granted last.
    function automatic logic pick(input logic [1:0] v, input logic last);
        if (v == 2'b11) return ~last;
        return v[1];
    endfunction

    function automatic logic [1:0] oh(input logic i);
        return i ? 2'b10 : 2'b01;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_ar();
        bus.s_arid    = {f_id[1],    f_id[0]};
        bus.s_araddr  = {f_addr[1],  f_addr[0]};
        bus.s_arlen   = {f_len[1],   f_len[0]};
        bus.s_arsize  = {f_size[1],  f_size[0]};
        bus.s_arburst = {f_burst[1], f_burst[0]};
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        bus.s_arvalid = 2'b11;
        repeat (2) @(posedge aclk);
        #1;
        checks++; if (bus.s_arready !== 2'b00) begin errors++; $display("FAIL reset_arready: got %b exp 00", bus.s_arready); end
        checks++; if (bus.m_arvalid !== 1'b0) begin errors++; $display("FAIL reset_m_arvalid: got %b exp 0", bus.m_arvalid); end
        checks++; if (bus.m_rready !== 1'b0) begin errors++; $display("FAIL reset_m_rready: got %b exp 0", bus.m_rready); end
        checks++; if (bus.s_rvalid !== 2'b00) begin errors++; $display("FAIL reset_s_rvalid: got %b exp 00", bus.s_rvalid); end
        checks++; if ({bus.m_arid, bus.m_araddr, bus.m_arlen} !== 40'h0) begin errors++; $display("FAIL reset_m_ar: got %h exp 0", {bus.m_arid, bus.m_araddr, bus.m_arlen}); end
        aresetn = 1'b1;
        bus.s_arvalid = 2'b00;
        model_last = ~FIRST_PRIO;
        tick();
    endtask

    task automatic test_tie();
        logic w;
        f_id[0] = 4'h1; f_addr[0] = 32'h0000_1000; f_len[0] = 4'd0; f_size[0] = 3'd2; f_burst[0] = BURST_INCR;
        f_id[1] = 4'h2; f_addr[1] = 32'h0000_2000; f_len[1] = 4'd0; f_size[1] = 3'd2; f_burst[1] = BURST_INCR;
        drive_ar();
        bus.s_arvalid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            w = pick(2'b11, model_last);
            #1;
            checks++; if (bus.s_arready !== oh(w)) begin errors++; $display("FAIL tie_arready[%0d]: got %b exp %b", k, bus.s_arready, oh(w)); end
            tick();
            model_last = w;
            if (k == 3) bus.s_arvalid = 2'b00;
            #1;
            checks++; if (bus.m_araddr !== f_addr[w]) begin errors++; $display("FAIL tie_araddr[%0d]: got %h exp %h", k, bus.m_araddr, f_addr[w]); end
            checks++; if (bus.s_arready !== 2'b00) begin errors++; $display("FAIL tie_arready_busy[%0d]: got %b exp 00", k, bus.s_arready); end
            bus.m_arready = 1'b1; tick(); bus.m_arready = 1'b0;
            bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.m_rdata = 32'h100 + k; bus.s_rready = 2'b11;
            #1;
            checks++; if (bus.s_rvalid !== oh(w)) begin errors++; $display("FAIL tie_rvalid[%0d]: got %b exp %b", k, bus.s_rvalid, oh(w)); end
            tick();
            bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
        end
        bus.s_rready = 2'b00;
    endtask

    task automatic test_single_inst();
        f_id[0] = 4'h3; f_addr[0] = 32'h1FC0_0000; f_len[0] = 4'd0; f_size[0] = 3'd2; f_burst[0] = BURST_INCR;
        drive_ar();
        bus.s_arvalid = 2'b01;
        #1;
        checks++; if (bus.s_arready !== 2'b01) begin errors++; $display("FAIL single_arready: got %b exp 01", bus.s_arready); end
        tick();
        model_last = 1'b0;
        bus.s_arvalid = 2'b00;
        #1;
        checks++; if (bus.m_arvalid !== 1'b1) begin errors++; $display("FAIL single_m_arvalid: got %b exp 1", bus.m_arvalid); end
        checks++; if ({bus.m_arid, bus.m_araddr, bus.m_arlen} !== {4'h3, 32'h1FC0_0000, 4'h0}) begin errors++; $display("FAIL single_m_ar: got %h exp %h", {bus.m_arid, bus.m_araddr, bus.m_arlen}, {4'h3, 32'h1FC0_0000, 4'h0}); end
        bus.m_arready = 1'b1; tick(); bus.m_arready = 1'b0;
        bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.m_rdata = 32'hDEAD_BEEF; bus.m_rid = 4'h3; bus.m_rresp = 2'b00; bus.s_rready = 2'b01;
        #1;
        checks++; if (bus.s_rvalid !== 2'b01) begin errors++; $display("FAIL single_rvalid: got %b exp 01", bus.s_rvalid); end
        checks++; if ({bus.s_rid, bus.s_rdata, bus.s_rlast} !== {4'h3, 32'hDEAD_BEEF, 1'b1}) begin errors++; $display("FAIL single_rpayload: got %h exp %h", {bus.s_rid, bus.s_rdata, bus.s_rlast}, {4'h3, 32'hDEAD_BEEF, 1'b1}); end
        checks++; if (bus.m_rready !== 1'b1) begin errors++; $display("FAIL single_m_rready: got %b exp 1", bus.m_rready); end
        tick();
        bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.s_rready = 2'b00;
        f_addr[0] = 32'h1FC0_0004; drive_ar();
        bus.s_arvalid = 2'b01;
        #1;
        checks++; if (bus.s_rvalid !== 2'b00) begin errors++; $display("FAIL single_rvalid_after: got %b exp 00", bus.s_rvalid); end
        checks++; if (bus.s_arready !== 2'b01) begin errors++; $display("FAIL single_idle_after_rlast: got %b exp 01", bus.s_arready); end
        tick();
        model_last = 1'b0;
        bus.s_arvalid = 2'b00;
        bus.m_arready = 1'b1; tick(); bus.m_arready = 1'b0;
        bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.s_rready = 2'b01;
        tick();
        bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.s_rready = 2'b00;
    endtask

    task automatic test_stall();
        int   b;
        logic rr;
        f_id[1] = 4'h5; f_addr[1] = 32'h8000_0040; f_len[1] = 4'd3; f_size[1] = 3'd2; f_burst[1] = BURST_INCR;
        drive_ar();
        bus.s_arvalid = 2'b10;
        #1;
        checks++; if (bus.s_arready !== 2'b10) begin errors++; $display("FAIL stall_arready: got %b exp 10", bus.s_arready); end
        tick();
        model_last = 1'b1;
        bus.s_arvalid = 2'b00;
        bus.s_araddr = '1;
        bus.s_arlen  = '1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if ({bus.m_arvalid, bus.m_arid, bus.m_araddr, bus.m_arlen, bus.m_arsize, bus.m_arburst} !== {1'b1, 4'h5, 32'h8000_0040, 4'd3, 3'd2, BURST_INCR}) begin
                errors++; $display("FAIL stall_ar_stable[%0d]: got %h exp %h", c, {bus.m_arvalid, bus.m_arid, bus.m_araddr, bus.m_arlen, bus.m_arsize, bus.m_arburst}, {1'b1, 4'h5, 32'h8000_0040, 4'd3, 3'd2, BURST_INCR});
            end
            tick();
        end
        bus.m_arready = 1'b1; tick(); bus.m_arready = 1'b0;
        b = 0;
        for (int c = 0; c < 10 && b < 4; c++) begin
            rr = !(c == 1 || c == 2);
            bus.m_rvalid = 1'b1; bus.m_rdata = 32'hA000_0000 + 32'(b); bus.m_rlast = (b == 3); bus.s_rready = {rr, 1'b1};
            #1;
            checks++; if (bus.m_rready !== rr) begin errors++; $display("FAIL stall_m_rready[%0d]: got %b exp %b", c, bus.m_rready, rr); end
            checks++; if (bus.s_rvalid !== 2'b10) begin errors++; $display("FAIL stall_rvalid[%0d]: got %b exp 10", c, bus.s_rvalid); end
            checks++; if (bus.s_rdata !== 32'hA000_0000 + 32'(b)) begin errors++; $display("FAIL stall_rdata[%0d]: got %h exp %h", c, bus.s_rdata, 32'hA000_0000 + 32'(b)); end
            tick();
            if (rr) b++;
        end
        bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.s_rready = 2'b00;
        checks++; if (b !== 4) begin errors++; $display("FAIL stall_beats: got %0d exp 4", b); end
        #1;
        checks++; if ({bus.s_rvalid, bus.m_arvalid} !== 3'b000) begin errors++; $display("FAIL stall_idle: got %b exp 000", {bus.s_rvalid, bus.m_arvalid}); end
    endtask

    task automatic test_pending_inst();
        logic w;
        f_id[1] = 4'h7; f_addr[1] = 32'h0000_4000; f_len[1] = 4'd1;
        f_id[0] = 4'h8; f_addr[0] = 32'h1FC0_0200; f_len[0] = 4'd0;
        drive_ar();
        bus.s_arvalid = 2'b10;
        #1;
        checks++; if (bus.s_arready !== 2'b10) begin errors++; $display("FAIL pend_data_arready: got %b exp 10", bus.s_arready); end
        tick();
        model_last = 1'b1;
        bus.s_arvalid = 2'b00;
        bus.m_arready = 1'b1; tick(); bus.m_arready = 1'b0;
        bus.s_arvalid = 2'b01; bus.s_rready = 2'b10;
        for (int b = 0; b < 2; b++) begin
            bus.m_rvalid = 1'b1; bus.m_rlast = (b == 1); bus.m_rdata = 32'h5500 + 32'(b);
            #1;
            checks++; if (bus.s_arready !== 2'b00) begin errors++; $display("FAIL pend_arready_busy[%0d]: got %b exp 00", b, bus.s_arready); end
            checks++; if (bus.s_rvalid !== 2'b10) begin errors++; $display("FAIL pend_rvalid[%0d]: got %b exp 10", b, bus.s_rvalid); end
            tick();
        end
        bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
        w = pick(2'b01, model_last);
        #1;
        checks++; if (bus.s_arready !== oh(w)) begin errors++; $display("FAIL pend_inst_grant: got %b exp %b", bus.s_arready, oh(w)); end
        tick();
        model_last = w;
        bus.s_arvalid = 2'b00;
        #1;
        checks++; if (bus.m_araddr !== f_addr[0]) begin errors++; $display("FAIL pend_inst_araddr: got %h exp %h", bus.m_araddr, f_addr[0]); end
        bus.m_arready = 1'b1; tick(); bus.m_arready = 1'b0;
        bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.s_rready = 2'b01;
        #1;
        checks++; if (bus.s_rvalid !== 2'b01) begin errors++; $display("FAIL pend_inst_rvalid: got %b exp 01", bus.s_rvalid); end
        tick();
        bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.s_rready = 2'b00;
    endtask

    task automatic test_reset_mid_burst();
        f_id[1] = 4'h9; f_addr[1] = 32'h0000_9000; f_len[1] = 4'd3;
        drive_ar();
        bus.s_arvalid = 2'b10;
        tick();
        bus.s_arvalid = 2'b00;
        bus.m_arready = 1'b1; tick(); bus.m_arready = 1'b0;
        bus.s_rready = 2'b10;
        for (int b = 0; b < 2; b++) begin
            bus.m_rvalid = 1'b1; bus.m_rlast = 1'b0; bus.m_rdata = 32'h7700 + 32'(b);
            tick();
        end
        bus.s_arvalid = 2'b01;
        #1;
        checks++; if (bus.m_rready !== 1'b1) begin errors++; $display("FAIL rstmid_pre_rready: got %b exp 1", bus.m_rready); end
        aresetn = 1'b0;
        #1;
        checks++; if ({bus.s_arready, bus.s_rvalid, bus.m_rready, bus.m_arvalid} !== 6'b0) begin errors++; $display("FAIL rstmid_ctrl: got %b exp 000000", {bus.s_arready, bus.s_rvalid, bus.m_rready, bus.m_arvalid}); end
        checks++; if ({bus.m_araddr, bus.s_rdata} !== 64'h0) begin errors++; $display("FAIL rstmid_data: got %h exp 0", {bus.m_araddr, bus.s_rdata}); end
        tick(); tick();
        bus.m_rvalid = 1'b0; bus.s_rready = 2'b00;
        aresetn = 1'b1;
        model_last = ~FIRST_PRIO;
        f_id[0] = 4'hA; f_addr[0] = 32'h1FC0_0300; f_len[0] = 4'd0;
        drive_ar();
        #1;
        checks++; if (bus.s_arready !== 2'b01) begin errors++; $display("FAIL rstmid_fresh_arready: got %b exp 01", bus.s_arready); end
        tick();
        model_last = 1'b0;
        bus.s_arvalid = 2'b00;
        #1;
        checks++; if (bus.m_araddr !== 32'h1FC0_0300) begin errors++; $display("FAIL rstmid_fresh_araddr: got %h exp 1fc00300", bus.m_araddr); end
        bus.m_arready = 1'b1; tick(); bus.m_arready = 1'b0;
        bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.m_rdata = 32'hCAFE_F00D; bus.s_rready = 2'b01;
        #1;
        checks++; if ({bus.s_rvalid, bus.s_rdata} !== {2'b01, 32'hCAFE_F00D}) begin errors++; $display("FAIL rstmid_fresh_beat: got %h exp %h", {bus.s_rvalid, bus.s_rdata}, {2'b01, 32'hCAFE_F00D}); end
        tick();
        bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.s_rready = 2'b00;
        #1;
        checks++; if ({bus.s_rvalid, bus.m_arvalid} !== 3'b000) begin errors++; $display("FAIL rstmid_fresh_idle: got %b exp 000", {bus.s_rvalid, bus.m_arvalid}); end
    endtask

    task automatic test_random(input int n);
        logic [1:0]        pend;
        logic              w, rv, rr, exp_last;
        int                d, b, cyc;
        logic [DATA_W-1:0] dat;
        logic [ID_W-1:0]   rid;
        pend = 2'b00;
        for (int t = 0; t < n; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1 || (pend == 2'b00 && i == 1))) begin
                    f_id[i] = ID_W'($urandom); f_addr[i] = $urandom; f_len[i] = LEN_W'($urandom_range(0, 3));
                    f_size[i] = SIZE_W'($urandom_range(0, 2)); f_burst[i] = BURST_W'($urandom_range(0, 2));
                    pend[i] = 1'b1;
                end
            end
            drive_ar();
            bus.s_arvalid = pend;
            w = pick(pend, model_last);
            #1;
            checks++; if (bus.s_arready !== oh(w)) begin errors++; $display("FAIL rnd_arready[%0d]: got %b exp %b pend %b", t, bus.s_arready, oh(w), pend); end
            tick();
            model_last = w;
            pend[w] = 1'b0;
            bus.s_arvalid = pend;
            d = $urandom_range(0, 3);
            for (int c = 0; c <= d; c++) begin
                bus.m_arready = (c == d);
                #1;
                checks++; if ({bus.m_arvalid, bus.m_arid, bus.m_araddr, bus.m_arlen, bus.m_arsize, bus.m_arburst} !== {1'b1, f_id[w], f_addr[w], f_len[w], f_size[w], f_burst[w]}) begin
                    errors++; $display("FAIL rnd_ar[%0d]: got %h exp %h", t, {bus.m_arvalid, bus.m_arid, bus.m_araddr, bus.m_arlen, bus.m_arsize, bus.m_arburst}, {1'b1, f_id[w], f_addr[w], f_len[w], f_size[w], f_burst[w]});
                end
                checks++; if (bus.s_arready !== 2'b00) begin errors++; $display("FAIL rnd_arready_addr[%0d]: got %b exp 00", t, bus.s_arready); end
                tick();
            end
            bus.m_arready = 1'b0;
            b = 0;
            for (cyc = 0; cyc < 100 && b <= int'(f_len[w]); cyc++) begin
                rv = ($urandom_range(0, 3) != 0);
                rr = ($urandom_range(0, 3) != 0);
                dat = $urandom; rid = ID_W'($urandom);
                exp_last = (b == int'(f_len[w]));
                bus.m_rvalid = rv; bus.m_rdata = dat; bus.m_rid = rid; bus.m_rresp = 2'(b); bus.m_rlast = exp_last;
                bus.s_rready = w ? {rr, 1'($urandom)} : {1'($urandom), rr};
                #1;
                checks++; if (bus.s_rvalid !== (rv ? oh(w) : 2'b00)) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %b exp %b", t, bus.s_rvalid, (rv ? oh(w) : 2'b00)); end
                checks++; if (bus.m_rready !== rr) begin errors++; $display("FAIL rnd_m_rready[%0d]: got %b exp %b", t, bus.m_rready, rr); end
                checks++; if ({bus.s_rid, bus.s_rdata, bus.s_rresp, bus.s_rlast} !== {rid, dat, 2'(b), exp_last}) begin errors++; $display("FAIL rnd_rpayload[%0d]: got %h exp %h", t, {bus.s_rid, bus.s_rdata, bus.s_rresp, bus.s_rlast}, {rid, dat, 2'(b), exp_last}); end
                checks++; if (bus.s_arready !== 2'b00) begin errors++; $display("FAIL rnd_arready_data[%0d]: got %b exp 00", t, bus.s_arready); end
                tick();
                if (rv && rr) b++;
            end
            bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.s_rready = 2'b00;
            checks++; if (b !== int'(f_len[w]) + 1) begin errors++; $display("FAIL rnd_beats[%0d]: got %0d exp %0d", t, b, int'(f_len[w]) + 1); end
        end
        bus.s_arvalid = 2'b00;
        #1;
        checks++; if ({bus.m_arvalid, bus.s_rvalid} !== 3'b000) begin errors++; $display("FAIL rnd_final_idle: got %b exp 000", {bus.m_arvalid, bus.s_rvalid}); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        aresetn = 1'b0;
        model_last = ~FIRST_PRIO;
        bus.s_arid = '0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_arsize = '0; bus.s_arburst = '0;
        bus.s_arvalid = '0; bus.s_rready = '0;
        bus.m_arready = 1'b0; bus.m_rid = '0; bus.m_rdata = '0; bus.m_rresp = '0;
        bus.m_rlast = 1'b0; bus.m_rvalid = 1'b0;
        test_reset();
        test_tie();
        test_single_inst();
        test_stall();
        test_pending_inst();
        test_reset_mid_burst();
        test_random(40);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-requester AXI3 read-channel arbiter: shares one AR/R master port between the instruction fetch port (index 0) and the data port (index 1) of the mmu.
- Sits between the mmu read channels and the top-level AXI read ports. The write channels bypass it and connect directly from the data port.
- One outstanding burst at a time. Round-robin grant; R beats are routed back to the granted requester.

Parameters:
ID_W, 4, AXI ID width
ADDR_W, 32, address width
DATA_W, 32, data width
FIRST_PRIO, 1, requester that wins the first tie after reset

Ports:
aclk  in  1  clock
aresetn  in  1  reset; asynchronous, active-low
s_arid  in  2*ID_W  packed {data,inst} AR id
s_araddr  in  2*ADDR_W  packed AR address
s_arlen  in  8  packed {data,inst} arlen[3:0]
s_arsize  in  6  packed arsize[2:0]
s_arburst  in  4  packed arburst[1:0]
s_arvalid  in  2  per-requester AR valid
s_arready  out  2  per-requester AR ready
s_rid  out  ID_W  R id, broadcast to both requesters
s_rdata  out  DATA_W  R data, broadcast
s_rresp  out  2  R response, broadcast
s_rlast  out  1  R last, broadcast
s_rvalid  out  2  per-requester R valid; only the granted bit is ever high
s_rready  in  2  per-requester R ready
m_arid  out  ID_W  downstream AR id
m_araddr  out  ADDR_W  downstream AR address
m_arlen  out  4  downstream burst length
m_arsize  out  3  downstream beat size
m_arburst  out  2  downstream burst type
m_arvalid  out  1  downstream AR valid
m_arready  in  1  downstream AR ready
m_rid  in  ID_W  downstream R id
m_rdata  in  DATA_W  downstream R data
m_rresp  in  2  downstream R response
m_rlast  in  1  downstream R last
m_rvalid  in  1  downstream R valid
m_rready  out  1  downstream R ready

Behaviour:
- Reset (aresetn=0, takes effect immediately, independent of aclk):
  - state=IDLE; last_grant=~FIRST_PRIO.
  - All outputs 0, including m_arvalid, m_rready, s_arready and s_rvalid.
  - Registered AR fields cleared.
  - A reset mid-burst abandons that burst; no recovery of it is attempted.
- FSM states IDLE, ADDR, DATA:
  - IDLE: if any s_arvalid is set, pick a winner.
    - If only one requester is valid, it wins.
    - If both are valid, the winner is the one that is not last_grant.
    - s_arready[winner]=1 combinationally in the same cycle.
    - On the clock edge: latch the winner's id/addr/len/size/burst, set grant=winner and last_grant=winner, go to ADDR.
  - ADDR: m_arvalid=1 and m_ar* driven from the latched registers, held stable until m_arready. On the m_arvalid&&m_arready edge, go to DATA.
  - DATA:
    - s_rvalid[grant]=m_rvalid; m_rready=s_rready[grant]; s_r* payload = m_r* (combinational pass-through).
    - On the m_rvalid&&m_rready&&m_rlast edge, go to IDLE.
- Latency:
  - AR accept in cycle N; m_arvalid first high in N+1.
  - The earliest next grant is in the cycle after the last beat. No back-to-back overlap.
- s_arready is never high in ADDR or DATA. A requester that is not granted keeps arvalid asserted (AXI rule) and is served next.
- The non-granted s_rvalid bit is always 0, and its s_rready is ignored.
- m_rid is not checked against the latched id; routing uses the grant register only.
- Slice widths follow the packing: requester i uses bits [i*W +: W].

Decomposition:
- Shared package holds:
  - requester index constants (REQ_INST=0, REQ_DATA=1);
  - the FSM state encoding (2-bit);
  - AXI burst encodings (INCR=2'b01).
- One natural sub-module: rr_arb2, the combinational round-robin pick (req[1:0], last -> gnt one-hot). Everything else is flat.

Test Plan:
- Single inst request araddr=0x1FC00000, arlen=0:
  - s_arready[0] is high in the request cycle; m_araddr=0x1FC00000 from the next cycle.
  - One R beat with rdata=0xDEADBEEF is seen on s_rvalid[0] only.
  - FSM is back in IDLE the cycle after rlast.
- Both requesters valid in the same cycle after reset:
  - data (FIRST_PRIO=1) is granted first, then inst.
  - With both held valid continuously, grants alternate data, inst, data.
- Data request arlen=3, m_arready delayed 5 cycles:
  - m_ar* stays stable while m_arvalid is high.
  - 4 beats are forwarded; s_rready[1] low for 2 cycles stalls m_rready for the same cycles.
- Inst request asserted while a data burst is in DATA state:
  - s_arready[0] stays 0 until the data rlast handshake; inst is granted in the following cycle.
- aresetn dropped mid-burst (after beat 2 of 4):
  - all outputs go to 0 immediately;
  - after release, a fresh inst request completes normally.
